// File: rtl/nes_pkg.sv
// Shared NES core definitions: OAM DMA register address, transfer size and FSM states.
package nes_pkg;

    localparam logic [15:0] DMA_REG_ADDR = 16'h4014;
    localparam int unsigned OAM_BYTES    = 256;

    typedef enum logic [2:0] {
        IDLE,
        HALT,
        ALIGN,
        READ,
        WRITE
    } dma_state_e;

endpackage

// File: rtl/oam_dma.sv
// Sprite OAM DMA: a CPU write to $4014 stalls the CPU and copies one page into OAM.
// Define OAM_DMA_ALIGN_EN to insert the odd-parity alignment cycle after HALT.
module oam_dma
    import nes_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET,
    input  logic        CPU_EN,
    input  logic        CPU_PARITY,
    input  logic [15:0] EA,
    input  logic [7:0]  DIN,
    input  logic        WREQ,
    output logic        CPU_CE,
    output logic        BUS_SEL,
    output logic [15:0] DMA_ADDR,
    input  logic [7:0]  DMA_RDATA,
    output logic [7:0]  OAM_ADDR,
    output logic [7:0]  OAM_DATA,
    output logic        OAM_WE,
    output logic        BUSY
);

    localparam logic [7:0] LAST_IDX = 8'(OAM_BYTES - 1);

    dma_state_e state_q, state_d;
    logic [7:0] page_q, page_d;
    logic [7:0] index_q, index_d;
    logic [7:0] data_q, data_d;

`ifndef OAM_DMA_ALIGN_EN
    logic parity_unused;
    assign parity_unused = CPU_PARITY;
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            page_q  <= '0;
            index_q <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            page_q  <= page_d;
            index_q <= index_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        page_d  = page_q;
        index_d = index_q;
        data_d  = data_q;
        if (CPU_EN) begin
            case (state_q)
                IDLE: begin
                    if (WREQ && (EA == DMA_REG_ADDR)) begin
                        page_d  = DIN;
                        index_d = '0;
                        state_d = HALT;
                    end
                end
                HALT: begin
`ifdef OAM_DMA_ALIGN_EN
                    state_d = CPU_PARITY ? ALIGN : READ;
`else
                    state_d = READ;
`endif
                end
                ALIGN: state_d = READ;
                READ: begin
                    data_d  = DMA_RDATA;
                    state_d = WRITE;
                end
                WRITE: begin
                    // index wraps within the page; the last byte ends the transfer
                    if (index_q == LAST_IDX) begin
                        state_d = IDLE;
                    end else begin
                        index_d = index_q + 8'd1;
                        state_d = READ;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        BUSY     = (state_q != IDLE);
        CPU_CE   = (state_q == IDLE);
        BUS_SEL  = (state_q != IDLE);
        DMA_ADDR = {page_q, index_q};
        OAM_ADDR = index_q;
        OAM_DATA = data_q;
        // strobe coincides with the exiting edge; reset on that edge suppresses it
        OAM_WE   = (state_q == WRITE) && CPU_EN && !RESET;
    end

endmodule
